traffic_phase_scheduler: RTL and testbench

- Four-approach intersection phase scheduler that shares one right-of-way among four requesting approaches.
- Runs a GREEN → YELLOW → ALL_RED phase sequence per approach and picks the next approach round-robin from vehicle sensor requests.
- Supports emergency preemption.
- Sits above the per-approach lamp drivers and feeds their 2-bit lamp codes; phase durations are counted in `tick` pulses from a shared prescaler.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_phase_scheduler_dwell_timer.sv | 20 ++
 rtl/traffic_phase_scheduler.sv | 118 +++++++++++
 tb/tb_traffic_phase_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: phase encoding,
// lamp codes and the round-robin approach search.
package traffic_pkg;

   typedef enum logic [1:0] {
      S_GREEN  = 2'd0,
      S_YELLOW = 2'd1,
      S_ALLRED = 2'd2
   } phase_t;

   localparam logic [1:0] LAMP_RED = 2'b00;
   localparam logic [1:0] LAMP_YEL = 2'b01;
   localparam logic [1:0] LAMP_GRN = 2'b10;

   // Search starts one past the last holder and wraps back to it, so the
   // nearest requester in rotation order wins.
   function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] last);
      logic [1:0] idx;
      rr_next = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_dwell_timer.sv
// Phase dwell counter: synchronous clear, advances on tick, saturates at all-ones.
module dwell_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             tick,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (tick && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach phase scheduler: GREEN -> YELLOW -> ALL_RED per approach,
// round-robin selection from vehicle requests, with emergency preemption.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int MIN_GREEN = 8,
   parameter int MAX_GREEN = 40,
   parameter int YELLOW    = 4,
   parameter int ALL_RED   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [3:0] req,
   input  logic       preempt_valid,
   input  logic [1:0] preempt_id,
   output logic [1:0] grant,
   output logic [7:0] lamp,
   output logic [1:0] phase,
   output logic       preempt_ack
);

   localparam logic [CNT_W-1:0] MIN_G_T = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_G_T = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW);
   localparam logic [CNT_W-1:0] RED_T   = CNT_W'(ALL_RED);

   phase_t           state;
   phase_t           state_next;
   logic [1:0]       grant_next;
   logic             pending;
   logic [1:0]       pend_id;
   logic             pend_clr;
   logic             ack_next;
   logic             other;
   logic             timer_clr;
   logic [CNT_W-1:0] timer;

   dwell_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .tick  (tick),
      .count (timer)
   );

   always_comb begin
      state_next = state;
      grant_next = grant;
      pend_clr   = 1'b0;
      ack_next   = 1'b0;
      other      = |(req & ~(4'b0001 << grant));
      case (state)
         S_ALLRED: begin
            if (timer >= RED_T) begin
               if (pending) begin
                  state_next = S_GREEN;
                  grant_next = pend_id;
                  pend_clr   = 1'b1;
                  ack_next   = 1'b1;
               end else if (|req) begin
                  state_next = S_GREEN;
                  grant_next = rr_next(req, grant);
               end
            end
         end
         S_GREEN: begin
            // A preemption for the approach already green is confirmed in place.
            if (pending && (pend_id != grant)) begin
               state_next = S_YELLOW;
            end else if (pending) begin
               pend_clr = 1'b1;
               ack_next = 1'b1;
            end else if (other && (((timer >= MIN_G_T) && !req[grant]) || (timer >= MAX_G_T))) begin
               state_next = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (timer >= YEL_T) state_next = S_ALLRED;
         end
         default: state_next = S_ALLRED;
      endcase
      timer_clr = (state_next != state);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_ALLRED;
         grant       <= 2'd3;
         pending     <= 1'b0;
         pend_id     <= 2'd0;
         preempt_ack <= 1'b0;
      end else begin
         state       <= state_next;
         grant       <= grant_next;
         preempt_ack <= ack_next;
         if (pend_clr) begin
            pending <= 1'b0;
         end else if (!pending && preempt_valid) begin
            pending <= 1'b1;
            pend_id <= preempt_id;
         end
      end
   end

   always_comb begin
      lamp = 8'h00;
      case (state)
         S_GREEN:  lamp[{grant, 1'b0} +: 2] = LAMP_GRN;
         S_YELLOW: lamp[{grant, 1'b0} +: 2] = LAMP_YEL;
         default:  lamp = 8'h00;
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler with short phase
// durations and tick asserted every cycle.
module tb_traffic_phase_scheduler;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [3:0] req;
   logic       preempt_valid;
   logic [1:0] preempt_id;
   logic [1:0] grant;
   logic [7:0] lamp;
   logic [1:0] phase;
   logic       preempt_ack;

   int n_checks = 0;
   int n_fail   = 0;

   traffic_phase_scheduler #(
      .CNT_W     (8),
      .MIN_GREEN (3),
      .MAX_GREEN (6),
      .YELLOW    (2),
      .ALL_RED   (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .req           (req),
      .preempt_valid (preempt_valid),
      .preempt_id    (preempt_id),
      .grant         (grant),
      .lamp          (lamp),
      .phase         (phase),
      .preempt_ack   (preempt_ack)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] r);
      rst_n         = 1'b0;
      req           = r;
      preempt_valid = 1'b0;
      preempt_id    = 2'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(4'b0000);
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if ({phase, grant, lamp, preempt_ack} !== {S_ALLRED, 2'd3, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got phase=%0d grant=%0d lamp=%h ack=%b, expected phase=2 grant=3 lamp=00 ack=0",
                     i, phase, grant, lamp, preempt_ack);
         end
         step();
      end
   endtask

   task automatic test_first_green();
      req = 4'b0001;
      step();
      n_checks++;
      if ({phase, grant, lamp} !== {S_GREEN, 2'd0, 8'h02}) begin
         n_fail++;
         $display("FAIL first_green: got phase=%0d grant=%0d lamp=%h, expected phase=0 grant=0 lamp=02", phase, grant, lamp);
      end
      for (int i = 0; i < 12; i++) step();
      n_checks++;
      if ({phase, grant, lamp} !== {S_GREEN, 2'd0, 8'h02}) begin
         n_fail++;
         $display("FAIL rest_green: got phase=%0d grant=%0d lamp=%h, expected phase=0 grant=0 lamp=02", phase, grant, lamp);
      end
   endtask

   task automatic test_max_out();
      int n;
      do_reset(4'b0101);
      n = 0;
      while (phase !== S_GREEN && n < 10) begin step(); n++; end
      n_checks++;
      if ({phase, grant} !== {S_GREEN, 2'd0}) begin
         n_fail++;
         $display("FAIL maxout_start: got phase=%0d grant=%0d, expected phase=0 grant=0", phase, grant);
      end
      n = 0;
      while (phase === S_GREEN && n < 50) begin n++; step(); end
      n_checks++;
      if (n !== 7) begin
         n_fail++;
         $display("FAIL maxout_green_len: got %0d cycles, expected 7", n);
      end
      n_checks++;
      if (lamp !== 8'h01) begin
         n_fail++;
         $display("FAIL maxout_yellow_lamp: got %h, expected 01", lamp);
      end
      n = 0;
      while (phase === S_YELLOW && n < 50) begin n++; step(); end
      n_checks++;
      if (n !== 3) begin
         n_fail++;
         $display("FAIL maxout_yellow_len: got %0d cycles, expected 3", n);
      end
      n = 0;
      while (phase === S_ALLRED && n < 50) begin n++; step(); end
      n_checks++;
      if (n !== 2) begin
         n_fail++;
         $display("FAIL maxout_allred_len: got %0d cycles, expected 2", n);
      end
      n_checks++;
      if ({phase, grant, lamp} !== {S_GREEN, 2'd2, 8'h20}) begin
         n_fail++;
         $display("FAIL maxout_next: got phase=%0d grant=%0d lamp=%h, expected phase=0 grant=2 lamp=20", phase, grant, lamp);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rr [4];
      int n;
      exp_rr = '{2'd2, 2'd3, 2'd0, 2'd1};
      req = 4'b0010;
      n = 0;
      while (!(phase === S_GREEN && grant === 2'd1) && n < 40) begin step(); n++; end
      n_checks++;
      if ({phase, grant} !== {S_GREEN, 2'd1}) begin
         n_fail++;
         $display("FAIL rr_setup: got phase=%0d grant=%0d, expected phase=0 grant=1", phase, grant);
      end
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (phase === S_GREEN && n < 40) begin step(); n++; end
         n = 0;
         while (phase !== S_GREEN && n < 40) begin step(); n++; end
         n_checks++;
         if ({phase, grant} !== {S_GREEN, exp_rr[i]}) begin
            n_fail++;
            $display("FAIL rr_order step %0d: got phase=%0d grant=%0d, expected phase=0 grant=%0d", i, phase, grant, exp_rr[i]);
         end
      end
   endtask

   task automatic test_preemption();
      int acks;
      int n;
      do_reset(4'b0001);
      step();
      step();
      n_checks++;
      if ({phase, grant} !== {S_GREEN, 2'd0}) begin
         n_fail++;
         $display("FAIL pre_green0: got phase=%0d grant=%0d, expected phase=0 grant=0", phase, grant);
      end
      step();
      preempt_valid = 1'b1;
      preempt_id    = 2'd3;
      step();
      n_checks++;
      if (phase !== S_GREEN) begin
         n_fail++;
         $display("FAIL pre_capture_cycle: got phase=%0d, expected 0", phase);
      end
      preempt_id = 2'd1;
      step();
      n_checks++;
      if ({phase, preempt_ack} !== {S_YELLOW, 1'b0}) begin
         n_fail++;
         $display("FAIL pre_early_yellow: got phase=%0d ack=%b, expected phase=1 ack=0", phase, preempt_ack);
      end
      preempt_valid = 1'b0;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (preempt_ack === 1'b1) acks++;
      end
      n_checks++;
      if ({phase, grant, lamp, preempt_ack} !== {S_GREEN, 2'd3, 8'h80, 1'b1}) begin
         n_fail++;
         $display("FAIL pre_green3: got phase=%0d grant=%0d lamp=%h ack=%b, expected phase=0 grant=3 lamp=80 ack=1",
                  phase, grant, lamp, preempt_ack);
      end
      step();
      if (preempt_ack === 1'b1) acks++;
      n_checks++;
      if (acks !== 1) begin
         n_fail++;
         $display("FAIL pre_ack_pulses: got %0d, expected 1", acks);
      end
      n = 0;
      while (phase === S_GREEN && n < 40) begin step(); n++; end
      n = 0;
      while (phase !== S_GREEN && n < 40) begin step(); n++; end
      n_checks++;
      if ({phase, grant, preempt_ack} !== {S_GREEN, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL pre_second_ignored: got phase=%0d grant=%0d ack=%b, expected phase=0 grant=0 ack=0", phase, grant, preempt_ack);
      end
   endtask

   task automatic test_preempt_confirm();
      preempt_valid = 1'b1;
      preempt_id    = 2'd0;
      step();
      preempt_valid = 1'b0;
      n_checks++;
      if ({phase, preempt_ack} !== {S_GREEN, 1'b0}) begin
         n_fail++;
         $display("FAIL confirm_capture: got phase=%0d ack=%b, expected phase=0 ack=0", phase, preempt_ack);
      end
      step();
      n_checks++;
      if ({phase, grant, preempt_ack} !== {S_GREEN, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL confirm_ack: got phase=%0d grant=%0d ack=%b, expected phase=0 grant=0 ack=1", phase, grant, preempt_ack);
      end
      step();
      n_checks++;
      if ({phase, preempt_ack} !== {S_GREEN, 1'b0}) begin
         n_fail++;
         $display("FAIL confirm_ack_drop: got phase=%0d ack=%b, expected phase=0 ack=0", phase, preempt_ack);
      end
   endtask

   task automatic test_sync_reset();
      int n;
      req = 4'b0011;
      n = 0;
      while (phase !== S_YELLOW && n < 40) begin step(); n++; end
      step();
      n_checks++;
      if ({phase, grant, lamp} !== {S_YELLOW, 2'd0, 8'h01}) begin
         n_fail++;
         $display("FAIL srst_mid_yellow: got phase=%0d grant=%0d lamp=%h, expected phase=1 grant=0 lamp=01", phase, grant, lamp);
      end
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({phase, grant, lamp} !== {S_YELLOW, 2'd0, 8'h01}) begin
         n_fail++;
         $display("FAIL srst_no_edge: got phase=%0d grant=%0d lamp=%h, expected phase=1 grant=0 lamp=01", phase, grant, lamp);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({phase, grant, lamp, preempt_ack} !== {S_ALLRED, 2'd3, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL srst_values: got phase=%0d grant=%0d lamp=%h ack=%b, expected phase=2 grant=3 lamp=00 ack=0",
                  phase, grant, lamp, preempt_ack);
      end
      req   = 4'b0001;
      rst_n = 1'b1;
      step();
      n_checks++;
      if (phase !== S_ALLRED) begin
         n_fail++;
         $display("FAIL srst_timer_cleared: got phase=%0d, expected 2", phase);
      end
      step();
      n_checks++;
      if ({phase, grant} !== {S_GREEN, 2'd0}) begin
         n_fail++;
         $display("FAIL srst_recover: got phase=%0d grant=%0d, expected phase=0 grant=0", phase, grant);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tick          = 1'b1;
      rst_n         = 1'b0;
      req           = 4'b0000;
      preempt_valid = 1'b0;
      preempt_id    = 2'd0;
      test_reset();
      test_first_green();
      test_max_out();
      test_round_robin();
      test_preemption();
      test_preempt_confirm();
      test_sync_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
